// File: rtl/cpu_bus_pkg.sv
// Shared encodings and width defaults for the CPU bus arbiter.
// Holds the FSM state codes, the owner codes and the default widths.
package cpu_bus_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = 4;

    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StAddr = 2'b01;
    localparam logic [1:0] StWait = 2'b10;

    localparam logic OwnInst = 1'b0;
    localparam logic OwnData = 1'b1;

endpackage

// File: rtl/cpu_bus_arbiter.sv
// Arbitrates instruction fetch and load/store onto one request/response memory port.
// Data has fixed priority, and at most one transaction is outstanding at a time.
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWidth,
    parameter int unsigned DATA_W = DataWidth
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inst_req,
    input  logic [ADDR_W-1:0]    inst_addr,
    output logic [DATA_W-1:0]    inst_rdata,
    output logic                 i_stall,
    input  logic                 data_req,
    input  logic                 data_wr,
    input  logic [StrbWidth-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]    data_addr,
    input  logic [DATA_W-1:0]    data_wdata,
    output logic [DATA_W-1:0]    data_rdata,
    output logic                 d_stall,
    input  logic                 longest_stall,
    output logic                 mem_req,
    output logic                 mem_wr,
    output logic [StrbWidth-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic                 mem_addr_ok,
    input  logic                 mem_data_ok,
    input  logic [DATA_W-1:0]    mem_rdata
);

    logic [1:0]           state_q, state_d;
    logic                 owner_q, owner_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 wr_q, wr_d;
    logic [StrbWidth-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 inst_done_q, inst_done_d;
    logic                 data_done_q, data_done_d;
    logic [DATA_W-1:0]    inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]    data_rdata_q, data_rdata_d;
    logic                 complete;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        complete = 1'b0;
        case (state_q)
            StIdle: begin
                // A port whose done flag is still set is never re-issued.
                if (data_req && !data_done_q) begin
                    owner_d = OwnData;
                    addr_d  = data_addr;
                    wr_d    = data_wr;
                    wstrb_d = data_wstrb;
                    wdata_d = data_wdata;
                    state_d = StAddr;
                end else if (inst_req && !inst_done_q) begin
                    owner_d = OwnInst;
                    addr_d  = inst_addr;
                    wr_d    = 1'b0;
                    wstrb_d = '0;
                    wdata_d = '0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (mem_addr_ok) begin
                    if (mem_data_ok) begin
                        complete = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (mem_data_ok) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Completion sets the flag; set wins, though it cannot meet a clear in practice.
    always_comb begin
        inst_done_d  = inst_done_q & longest_stall;
        data_done_d  = data_done_q & longest_stall;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        if (complete) begin
            if (owner_q == OwnInst) begin
                inst_done_d  = 1'b1;
                inst_rdata_d = mem_rdata;
            end else begin
                data_done_d = 1'b1;
                if (!wr_q) begin
                    data_rdata_d = mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            owner_q      <= OwnInst;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign mem_req    = (state_q == StAddr);
    assign mem_wr     = wr_q;
    assign mem_wstrb  = wstrb_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign i_stall    = inst_req & ~inst_done_q;
    assign d_stall    = data_req & ~data_done_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: a transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        i_stall;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        d_stall;
    logic        longest_stall;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    cpu_bus_arbiter #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata),
        .i_stall      (i_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .d_stall      (d_stall),
        .longest_stall(longest_stall),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding access, whether its address was accepted,
    // per-port done flags and the captured read results.
    bit          m_started = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_acc = 1'b0;
    logic        m_clean = 1'b1;
    logic        m_owner = 1'b0;
    logic        m_wr = 1'b0;
    logic [3:0]  m_wstrb = '0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic        m_idone = 1'b0;
    logic        m_ddone = 1'b0;
    logic [31:0] m_irdata = '0;
    logic [31:0] m_drdata = '0;

    task model_step;
        logic fin, id0, dd0;
        if (!rst) begin
            m_busy = 0; m_acc = 0; m_clean = 1; m_owner = 0; m_wr = 0; m_wstrb = '0;
            m_addr = '0; m_wdata = '0; m_idone = 0; m_ddone = 0; m_irdata = '0; m_drdata = '0;
        end else begin
            fin = m_busy && mem_data_ok && (m_acc || mem_addr_ok);
            id0 = m_idone;
            dd0 = m_ddone;
            if (!longest_stall) begin
                m_idone = 0;
                m_ddone = 0;
            end
            if (!m_busy) begin
                if (data_req && !dd0) begin
                    m_busy = 1; m_acc = 0; m_clean = 0; m_owner = 1; m_wr = data_wr;
                    m_wstrb = data_wstrb; m_addr = data_addr; m_wdata = data_wdata;
                end else if (inst_req && !id0) begin
                    m_busy = 1; m_acc = 0; m_clean = 0; m_owner = 0; m_wr = 0;
                    m_wstrb = '0; m_addr = inst_addr; m_wdata = '0;
                end
            end else if (fin) begin
                m_busy = 0;
                if (m_owner) begin
                    m_ddone = 1;
                    if (!m_wr) m_drdata = mem_rdata;
                end else begin
                    m_idone = 1;
                    m_irdata = mem_rdata;
                end
            end else if (mem_addr_ok) begin
                m_acc = 1;
            end
        end
        m_started = 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Single compare process, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (m_started) begin
            check("mem_req", mem_req, m_busy && !m_acc);
            check("i_stall", i_stall, inst_req && !m_idone);
            check("d_stall", d_stall, data_req && !m_ddone);
            check("inst_rdata", inst_rdata, m_irdata);
            check("data_rdata", data_rdata, m_drdata);
            if ((m_busy && !m_acc) || m_clean) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_wr", mem_wr, m_wr);
                check("mem_wstrb", mem_wstrb, m_wstrb);
                if (m_owner || m_clean) check("mem_wdata", mem_wdata, m_wdata);
            end
        end
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task quiet;
        rst = 1; inst_req = 0; inst_addr = '0; data_req = 0; data_wr = 0; data_wstrb = '0;
        data_addr = '0; data_wdata = '0; longest_stall = 0; mem_addr_ok = 0;
        mem_data_ok = 0; mem_rdata = '0;
    endtask

    initial begin
        quiet();
        rst = 0;
        tick(); tick();
        @(negedge clk);
        check("reset_mem_req", mem_req, 0);
        check("reset_rdata", inst_rdata | data_rdata, 0);
        tick();
        rst = 1;
        tick();

        // Fetch with addr_ok in cycle 2 and data_ok in cycle 4.
        quiet(); inst_req = 1; inst_addr = 32'hBFC00000;
        for (int c = 0; c < 7; c++) begin
            mem_addr_ok = (c == 2);
            mem_data_ok = (c == 4);
            mem_rdata = (c == 4) ? 32'h24010001 : 32'h0;
            if (c == 6) inst_req = 0;
            @(negedge clk);
            if (c <= 4) check("fetch_i_stall_busy", i_stall, 1);
            if (c == 1) check("fetch_mem_addr", mem_addr, 32'hBFC00000);
            if (c == 3) check("fetch_wait_no_req", mem_req, 0);
            if (c == 5) begin
                check("fetch_rdata", inst_rdata, 32'h24010001);
                check("fetch_i_stall_done", i_stall, 0);
                check("model_fetch_rdata", m_irdata, 32'h24010001);
            end
            tick();
        end

        // Contention: data is issued first, fetch only after it completes.
        quiet(); inst_req = 1; inst_addr = 32'hBFC00004; data_req = 1; data_addr = 32'h80000010;
        mem_addr_ok = 1; mem_data_ok = 1;
        for (int c = 0; c < 6; c++) begin
            mem_rdata = (c == 1) ? 32'h11112222 : ((c == 3) ? 32'h33334444 : 32'h0);
            if (c == 3) data_req = 0;
            if (c == 5) inst_req = 0;
            @(negedge clk);
            if (c == 1) begin
                check("cont_first_addr", mem_addr, 32'h80000010);
                check("cont_first_req", mem_req, 1);
                check("cont_i_stall", i_stall, 1);
            end
            if (c == 2) begin
                check("cont_gap_req", mem_req, 0);
                check("cont_d_stall", d_stall, 0);
                check("cont_load_rdata", data_rdata, 32'h11112222);
            end
            if (c == 3) check("cont_second_addr", mem_addr, 32'hBFC00004);
            if (c == 4) check("cont_inst_rdata", inst_rdata, 32'h33334444);
            tick();
        end

        // Zero-wait store leaves data_rdata untouched.
        quiet(); data_req = 1; data_wr = 1; data_wstrb = 4'b0011; data_wdata = 32'h0000BEEF;
        data_addr = 32'h80000020; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hDEADDEAD;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) data_req = 0;
            @(negedge clk);
            if (c < 2) check("store_d_stall_busy", d_stall, 1);
            if (c == 1) begin
                check("store_wstrb", mem_wstrb, 4'b0011);
                check("store_wr", mem_wr, 1);
                check("store_wdata", mem_wdata, 32'h0000BEEF);
            end
            if (c == 2) begin
                check("store_d_stall_done", d_stall, 0);
                check("store_rdata_kept", data_rdata, 32'h11112222);
            end
            tick();
        end

        // Completed fetch held by longest_stall for 3 cycles.
        quiet(); inst_req = 1; inst_addr = 32'hBFC00008; mem_addr_ok = 1; mem_data_ok = 1;
        mem_rdata = 32'h00000013;
        for (int c = 0; c < 10; c++) begin
            longest_stall = (c >= 2 && c <= 4);
            if (c == 7) inst_req = 0;
            @(negedge clk);
            if (c >= 2 && c <= 6) check("hold_no_reissue", mem_req, 0);
            if (c >= 2 && c <= 5) check("hold_i_stall_low", i_stall, 0);
            if (c == 6) begin
                check("hold_done_cleared", i_stall, 1);
                check("hold_rdata", inst_rdata, 32'h00000013);
            end
            tick();
        end

        // Reset while waiting for data; the late data_ok is ignored.
        quiet(); data_req = 1; data_addr = 32'h80000030;
        for (int c = 0; c < 5; c++) begin
            mem_addr_ok = (c == 1);
            mem_data_ok = (c == 3);
            mem_rdata = (c == 3) ? 32'hCAFEBABE : 32'h0;
            rst = (c != 2);
            if (c == 2) data_req = 0;
            @(negedge clk);
            if (c == 2) check("rst_wait_no_req", mem_req, 0);
            if (c >= 3) begin
                check("rst_mem_req", mem_req, 0);
                check("rst_data_rdata", data_rdata, 0);
                check("rst_inst_rdata", inst_rdata, 0);
                check("rst_mem_addr", mem_addr, 0);
            end
            tick();
        end

        // Backpressure with the requester flushing mid-transaction.
        quiet(); data_req = 1; data_wr = 1; data_wstrb = 4'b1100; data_wdata = 32'h12345678;
        data_addr = 32'h80000040;
        for (int c = 0; c < 9; c++) begin
            mem_addr_ok = (c == 6);
            mem_data_ok = (c == 6);
            if (c == 3) begin
                data_req = 0; data_addr = 32'h0BAD0BAD; data_wdata = 32'hFFFFFFFF;
                data_wstrb = 4'b1111;
            end
            @(negedge clk);
            if (c >= 1 && c <= 6) begin
                check("bp_req", mem_req, 1);
                check("bp_addr", mem_addr, 32'h80000040);
                check("bp_wdata", mem_wdata, 32'h12345678);
                check("bp_wstrb", mem_wstrb, 4'b1100);
            end
            if (c == 7) check("bp_done", mem_req, 0);
            tick();
        end

        // Randomized traffic, occasional resets and spurious responses.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom % 150) != 0;
            inst_req = $urandom % 2;
            inst_addr = $urandom;
            data_req = ($urandom % 3) == 0;
            data_wr = $urandom % 2;
            data_wstrb = 4'($urandom);
            data_addr = $urandom;
            data_wdata = $urandom;
            longest_stall = ($urandom % 4) == 0;
            mem_addr_ok = ($urandom % 3) == 0;
            mem_data_ok = ($urandom % 3) == 0;
            mem_rdata = $urandom;
            tick();
        end

        quiet();
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
